// File: rtl/lcd_pkg.sv
// Shared LCD pixel-path definitions: raster defaults, pixel word fields and fetch states.
package lcd_pkg;

  localparam int unsigned DefaultHPixels = 800;
  localparam int unsigned DefaultVPixels = 480;

  localparam int unsigned PixelWidth = 24;
  localparam int unsigned RedMsb     = 23;
  localparam int unsigned RedLsb     = 16;
  localparam int unsigned GreenMsb   = 15;
  localparam int unsigned GreenLsb   = 8;
  localparam int unsigned BlueMsb    = 7;
  localparam int unsigned BlueLsb    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitData,
    StDrain,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and synchronous flush.
module sync_fifo #(
  parameter int unsigned Width     = 24,
  parameter int unsigned Log2Depth = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [Width-1:0]     wdata,
  input  logic                 pop,
  output logic [Width-1:0]     rdata,
  output logic                 empty,
  output logic [Log2Depth:0]   count
);

  localparam int unsigned Depth = 1 << Log2Depth;
  localparam int unsigned CntW  = Log2Depth + 1;

  logic [Width-1:0]     mem [Depth];
  logic [Log2Depth-1:0] wr_ptr;
  logic [Log2Depth-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush && (count != CntW'(Depth));
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// Streams frame-buffer pixels from SDRAM through a FIFO to the LCD colour registers,
// fetching with single outstanding Avalon-MM bursts.
module frame_buffer_reader
  import lcd_pkg::*;
#(
  parameter logic [31:0] FB_BASE         = 32'h3800_0000,
  parameter int unsigned H_PIXELS        = DefaultHPixels,
  parameter int unsigned V_PIXELS        = DefaultVPixels,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned LOG2_FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        data_enable,
  input  logic        next_frame,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underflow,
  output logic [31:0] avm_address,
  output logic [4:0]  avm_burstcount,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned TotalWords = H_PIXELS * V_PIXELS;
  localparam int unsigned WordsW     = $clog2(TotalWords + 1);
  localparam int unsigned FifoDepth  = 1 << LOG2_FIFO_DEPTH;
  localparam int unsigned CntW       = LOG2_FIFO_DEPTH + 1;
  localparam int unsigned BeatW      = $clog2(BURST_LEN + 1);
  localparam logic [31:0] BurstBytes = 32'(4 * BURST_LEN);

  fetch_state_e        state;
  logic [31:0]         fetch_addr;
  logic [WordsW-1:0]   words_left;
  logic [BeatW-1:0]    beat_cnt;
  logic                drain_pending;

  logic [PixelWidth-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  has_room;
  logic                  beat_last;
  logic                  unused_readdata;

  assign avm_burstcount  = 5'(BURST_LEN);
  assign unused_readdata = ^avm_readdata[31:PixelWidth];

  assign has_room  = (fifo_count <= CntW'(FifoDepth - BURST_LEN));
  assign beat_last = avm_readdatavalid && (beat_cnt == BeatW'(BURST_LEN - 1));
  assign fifo_push = avm_readdatavalid && (state == StWaitData) && !next_frame;
  assign fifo_pop  = tick && data_enable && !fifo_empty && !next_frame;

  sync_fifo #(
    .Width     (PixelWidth),
    .Log2Depth (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (next_frame),
    .push  (fifo_push),
    .wdata (avm_readdata[RedMsb:BlueLsb]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      fetch_addr    <= FB_BASE;
      words_left    <= WordsW'(TotalWords);
      beat_cnt      <= '0;
      drain_pending <= 1'b0;
      avm_read      <= 1'b0;
      avm_address   <= FB_BASE;
    end else begin
      if (next_frame) begin
        fetch_addr <= FB_BASE;
        words_left <= WordsW'(TotalWords);
      end
      case (state)
        StIdle: begin
          if (!next_frame && (words_left != '0) && has_room) begin
            avm_read    <= 1'b1;
            avm_address <= fetch_addr;
            state       <= StIssue;
          end
        end
        StIssue: begin
          // A posted command is never withdrawn; a restart only redirects its data to DRAIN.
          if (!avm_waitrequest) begin
            avm_read      <= 1'b0;
            beat_cnt      <= '0;
            drain_pending <= 1'b0;
            state         <= (next_frame || drain_pending) ? StDrain : StWaitData;
          end else if (next_frame) begin
            drain_pending <= 1'b1;
          end
        end
        StWaitData: begin
          if (avm_readdatavalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_last) begin
              beat_cnt <= '0;
              if (next_frame) begin
                state <= StIdle;
              end else begin
                fetch_addr <= fetch_addr + BurstBytes;
                words_left <= words_left - WordsW'(BURST_LEN);
                state      <= (words_left == WordsW'(BURST_LEN)) ? StDone : StIdle;
              end
            end else if (next_frame) begin
              state <= StDrain;
            end
          end else if (next_frame) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (avm_readdatavalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_last) begin
              beat_cnt <= '0;
              state    <= StIdle;
            end
          end
        end
        StDone: begin
          if (next_frame) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      underflow <= 1'b0;
    end else if (next_frame) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      underflow <= 1'b0;
    end else if (tick) begin
      if (data_enable && !fifo_empty) begin
        red   <= fifo_rdata[RedMsb:RedLsb];
        green <= fifo_rdata[GreenMsb:GreenLsb];
        blue  <= fifo_rdata[BlueMsb:BlueLsb];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
        if (data_enable) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Randomized bench for frame_buffer_reader: Avalon slave model plus a queue-based pixel model.
module tb_frame_buffer_reader;

  localparam logic [31:0] FbBase    = 32'h3800_0000;
  localparam int          HPix      = 16;
  localparam int          VPix      = 8;
  localparam int          Burst     = 16;
  localparam int          Log2Depth = 5;
  localparam int          Depth     = 1 << Log2Depth;
  localparam int          Total     = HPix * VPix;
  localparam int          NBursts   = Total / Burst;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        data_enable = 1'b0;
  logic        next_frame = 1'b0;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        underflow;
  logic [31:0] avm_address;
  logic [4:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  frame_buffer_reader #(
    .FB_BASE         (FbBase),
    .H_PIXELS        (HPix),
    .V_PIXELS        (VPix),
    .BURST_LEN       (Burst),
    .LOG2_FIFO_DEPTH (Log2Depth)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .tick              (tick),
    .data_enable       (data_enable),
    .next_frame        (next_frame),
    .red               (red),
    .green             (green),
    .blue              (blue),
    .underflow         (underflow),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents and outputs, plus burst bookkeeping.
  logic [23:0] mq[$];
  logic [23:0] exp_rgb;
  logic        exp_uf;
  bit          outstanding, drop, cmd_drop, req_active, wait_fixed;
  int          beats_left, burst_idx, bursts_in_frame, pops, wait_cnt, wait_max, beat_pct;
  logic [31:0] next_exp_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rgb         = '0;
    exp_uf          = 1'b0;
    outstanding     = 0;
    drop            = 0;
    cmd_drop        = 0;
    req_active      = 0;
    beats_left      = 0;
    bursts_in_frame = 0;
    wait_cnt        = 0;
    next_exp_addr   = FbBase;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
  endtask

  task automatic step_cycle(input bit t, input bit d, input bit n);
    bit          rd, acc, beat, pend;
    logic [23:0] bdata;
    logic [31:0] held_addr;
    tick        = t;
    data_enable = d;
    next_frame  = n;
    rd        = avm_read;
    acc       = rd && !avm_waitrequest;
    pend      = rd && avm_waitrequest;
    held_addr = avm_address;
    beat      = avm_readdatavalid;
    bdata     = avm_readdata[23:0];
    if (acc) req_active = 0;

    if (n) begin
      mq.delete();
      exp_rgb = '0;
      exp_uf  = 1'b0;
    end else if (t) begin
      if (d) begin
        if (mq.size() == 0) begin
          exp_rgb = '0;
          exp_uf  = 1'b1;
        end else begin
          exp_rgb = mq.pop_front();
          pops++;
        end
      end else begin
        exp_rgb = '0;
      end
    end
    if (beat) begin
      if (!drop && !n) mq.push_back(bdata);
      beats_left--;
      if (beats_left == 0) begin
        outstanding = 0;
        drop        = 0;
      end
    end
    if (n) begin
      if (outstanding) drop = 1;
      if (rd && !acc) cmd_drop = 1;
      next_exp_addr   = FbBase;
      bursts_in_frame = 0;
    end
    if (acc) begin
      outstanding = 1;
      beats_left  = Burst;
      drop        = cmd_drop || n;
      cmd_drop    = 0;
      burst_idx   = int'((held_addr - FbBase) >> 2);
    end

    @(posedge clock);
    #1;
    check_val("rgb", {red, green, blue}, exp_rgb);
    check_val("underflow", underflow, exp_uf);
    if (pend) begin
      check_val("hold_read", avm_read, 1);
      check_val("hold_addr", avm_address, held_addr);
      check_val("hold_burstcount", avm_burstcount, Burst);
    end

    avm_waitrequest = 1'b0;
    if (avm_read) begin
      if (!req_active) begin
        req_active = 1;
        check_val("req_addr", avm_address, next_exp_addr);
        check_val("req_burstcount", avm_burstcount, Burst);
        check_val("req_in_frame", bursts_in_frame < NBursts, 1);
        check_val("req_room", mq.size() <= Depth - Burst, 1);
        check_val("req_single_outstanding", outstanding, 0);
        next_exp_addr += 32'(4 * Burst);
        bursts_in_frame++;
        wait_cnt = wait_fixed ? wait_max : $urandom_range(0, wait_max);
      end
      avm_waitrequest = (wait_cnt > 0);
      if (wait_cnt > 0) wait_cnt--;
    end

    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (outstanding && beats_left > 0 && $urandom_range(0, 99) < beat_pct) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = {8'($urandom), 24'(burst_idx + Burst - beats_left)};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    pops       = 0;
    wait_max   = 0;
    wait_fixed = 0;
    beat_pct   = 100;
    #23;
    check_val("reset_rgb", {red, green, blue}, 0);
    check_val("reset_underflow", underflow, 0);
    check_val("reset_read", avm_read, 0);
    check_val("reset_addr", avm_address, FbBase);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill with zero wait states: two bursts fit, then fetching stalls.
    repeat (60) step_cycle(0, 0, 0);
    check_val("fill_bursts", bursts_in_frame, 2);

    // Full-frame stream with random blanking ticks.
    beat_pct = 80;
    wait_max = 2;
    for (int i = 0; i < 4000 && pops < Total; i++) begin
      step_cycle(i % 3 == 0, $urandom_range(0, 99) < 85, 0);
    end
    check_val("stream_pops", pops, Total);
    check_val("stream_underflow", underflow, 0);
    repeat (40) step_cycle(0, 0, 0);
    check_val("done_bursts", bursts_in_frame, NBursts);
    check_val("done_idle", avm_read, 0);

    // Seven-cycle waitrequest on every command.
    step_cycle(0, 0, 1);
    wait_max   = 7;
    wait_fixed = 1;
    beat_pct   = 100;
    repeat (80) step_cycle(0, 0, 0);
    check_val("wait_bursts", bursts_in_frame, 2);
    repeat (20) step_cycle(1, 1, 0);

    // Starved FIFO: underflow sets and sticks until next_frame.
    step_cycle(0, 0, 1);
    wait_fixed = 0;
    wait_max   = 0;
    beat_pct   = 3;
    for (int i = 0; i < 40; i++) step_cycle(i % 2 == 0, 1, 0);
    check_val("uf_set", underflow, 1);
    repeat (30) step_cycle(0, 0, 0);
    check_val("uf_held", underflow, 1);
    step_cycle(0, 0, 1);
    check_val("uf_cleared", underflow, 0);

    // Restart after beat 5 of a live burst.
    beat_pct = 100;
    step_cycle(0, 0, 1);
    for (int i = 0; i < 300 && !(outstanding && !drop && beats_left == Burst - 5); i++) begin
      step_cycle(0, 0, 0);
    end
    check_val("restart_at_beat5", beats_left, Burst - 5);
    step_cycle(0, 0, 1);
    repeat (40) step_cycle(0, 0, 0);
    step_cycle(1, 1, 0);
    check_val("restart_px0", {red, green, blue}, 0);
    check_val("restart_uf", underflow, 0);
    step_cycle(1, 1, 0);
    check_val("restart_px1", {red, green, blue}, 1);

    // Asynchronous reset while data beats are in flight.
    beat_pct = 50;
    step_cycle(0, 0, 1);
    for (int i = 0; i < 300 && !(outstanding && !drop && beats_left > 0 && beats_left < Burst);
         i++) begin
      step_cycle(i % 4 == 0, 1, 0);
    end
    check_val("areset_mid_burst", outstanding && beats_left > 0 && beats_left < Burst, 1);
    #3;
    reset       = 1'b1;
    tick        = 1'b0;
    data_enable = 1'b0;
    next_frame  = 1'b0;
    #1;
    check_val("areset_rgb", {red, green, blue}, 0);
    check_val("areset_underflow", underflow, 0);
    check_val("areset_read", avm_read, 0);
    check_val("areset_addr", avm_address, FbBase);
    model_reset();
    @(posedge clock);
    #1;
    reset    = 1'b0;
    beat_pct = 100;
    repeat (60) step_cycle(0, 0, 0);
    check_val("post_reset_bursts", bursts_in_frame, 2);
    repeat (10) step_cycle(1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
